// File: rtl/pwm_capture.sv
// pwm_capture: four-channel PWM input capture timing rise-to-fall (high) and rise-to-rise (period)
// against a shared power-of-two prescaled tick. Build macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample filter.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_pins,
    input  logic [3:0]         reg_cap_en,
    input  logic [7:0]         reg_cap_src_1_0,
    input  logic [7:0]         reg_cap_src_3_2,
    input  logic [3:0]         reg_cap_prescale,
    input  logic [3:0]         cap_ack,
    output logic [4*CNT_W-1:0] cap_high,
    output logic [4*CNT_W-1:0] cap_period,
    output logic [3:0]         cap_valid,
    output logic [3:0]         cap_overflow,
    output logic [3:0]         cap_level
);
    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_ARM      = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_LOW      = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [14:0] pre_cnt;
    logic [14:0] pre_mask;
    logic        tick;
    logic [15:0] src_all;
    logic        unused_src_bits;

    // Tick fires when the low n prescaler bits are all ones; n = 0 gives an all-zero mask.
    assign pre_mask = 15'((16'd1 << reg_cap_prescale) - 16'd1);
    assign tick     = &(pre_cnt | ~pre_mask);
    assign src_all  = {reg_cap_src_3_2, reg_cap_src_1_0};
    assign unused_src_bits = ^{reg_cap_src_1_0[7], reg_cap_src_1_0[3], reg_cap_src_3_2[7], reg_cap_src_3_2[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 15'd1;
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_ch
        logic [2:0]       src_sel;
        logic [2:0]       src_q;
        logic             sync1;
        logic             sync2;
        logic             level;
        logic             prev;
        logic             rise;
        logic             fall;
        logic             src_chg;
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] hold;
        logic [CNT_W-1:0] high_q;
        logic [CNT_W-1:0] period_q;
        logic             valid_q;
        logic             ovf_q;

        assign src_sel = src_all[c*4 +: 3];
        assign src_chg = (src_sel != src_q);
        assign count   = cnt + {{(CNT_W-1){1'b0}}, tick};
        assign rise    = level & ~prev;
        assign fall    = ~level & prev;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                prev  <= 1'b0;
                src_q <= '0;
            end else begin
                sync1 <= in_pins[src_sel];
                sync2 <= sync1;
                prev  <= level;
                src_q <= src_sel;
            end
        end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        logic d1;
        logic d2;
        logic filt_q;

        // Level only moves once three consecutive synchronised samples agree.
        assign level = ((sync2 == d1) && (d1 == d2)) ? sync2 : filt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d1     <= 1'b0;
                d2     <= 1'b0;
                filt_q <= 1'b0;
            end else begin
                d1     <= sync2;
                d2     <= d1;
                filt_q <= level;
            end
        end
`else
        assign level = sync2;
`endif

        // Later assignments override the ack clear, so a capture or overflow wins over cap_ack.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_DISABLED;
                cnt      <= '0;
                hold     <= '0;
                high_q   <= '0;
                period_q <= '0;
                valid_q  <= 1'b0;
                ovf_q    <= 1'b0;
            end else if (!reg_cap_en[c]) begin
                state   <= ST_DISABLED;
                cnt     <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                if (cap_ack[c]) begin
                    valid_q <= 1'b0;
                    ovf_q   <= 1'b0;
                end
                if (state == ST_DISABLED || src_chg) begin
                    state <= ST_ARM;
                    cnt   <= '0;
                end else begin
                    case (state)
                        ST_ARM: begin
                            cnt <= '0;
                            if (rise) begin
                                state <= ST_HIGH;
                            end
                        end
                        ST_HIGH: begin
                            if (fall) begin
                                hold  <= count;
                                cnt   <= count;
                                state <= ST_LOW;
                            end else if (count == CNT_MAX) begin
                                ovf_q   <= 1'b1;
                                valid_q <= 1'b0;
                                cnt     <= '0;
                                state   <= ST_ARM;
                            end else begin
                                cnt <= count;
                            end
                        end
                        default: begin
                            if (rise) begin
                                high_q   <= hold;
                                period_q <= count;
                                valid_q  <= 1'b1;
                                cnt      <= '0;
                                state    <= ST_HIGH;
                            end else if (count == CNT_MAX) begin
                                ovf_q   <= 1'b1;
                                valid_q <= 1'b0;
                                cnt     <= '0;
                                state   <= ST_ARM;
                            end else begin
                                cnt <= count;
                            end
                        end
                    endcase
                end
            end
        end

        assign cap_high[c*CNT_W +: CNT_W]   = high_q;
        assign cap_period[c*CNT_W +: CNT_W] = period_q;
        assign cap_valid[c]                 = valid_q;
        assign cap_overflow[c]              = ovf_q;
        assign cap_level[c]                 = level;
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: PWM generators on the pins, expectations derived from each waveform's
// high/period in cycles divided by the tick interval.
module tb_pwm_capture;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         in_pins;
    logic [3:0]         reg_cap_en;
    logic [7:0]         reg_cap_src_1_0;
    logic [7:0]         reg_cap_src_3_2;
    logic [3:0]         reg_cap_prescale;
    logic [3:0]         cap_ack;
    logic [4*CNT_W-1:0] cap_high;
    logic [4*CNT_W-1:0] cap_period;
    logic [3:0]         cap_valid;
    logic [3:0]         cap_overflow;
    logic [3:0]         cap_level;

    int pwm_hi[8];
    int pwm_per[8];
    int ph[8];
    int gl_pos[8];
    bit pwm_on[8];
    bit pin_static[8];

    int checks = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_q[$];

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_pins(in_pins), .reg_cap_en(reg_cap_en),
        .reg_cap_src_1_0(reg_cap_src_1_0), .reg_cap_src_3_2(reg_cap_src_3_2),
        .reg_cap_prescale(reg_cap_prescale), .cap_ack(cap_ack), .cap_high(cap_high),
        .cap_period(cap_period), .cap_valid(cap_valid), .cap_overflow(cap_overflow),
        .cap_level(cap_level)
    );

    always #5 clk = ~clk;

    // Pin driver: each pin is either a static level or a PWM wave starting with its rising edge.
    initial begin
        in_pins = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int p = 0; p < 8; p++) begin
                if (pwm_on[p]) begin
                    in_pins[p] = ((ph[p] < pwm_hi[p]) || (ph[p] == gl_pos[p])) ? 1'b1 : 1'b0;
                    ph[p] = (ph[p] + 1 >= pwm_per[p]) ? 0 : ph[p] + 1;
                end else begin
                    in_pins[p] = pin_static[p];
                end
            end
        end
    end

    function automatic logic [CNT_W-1:0] hi_of(input int c);
        return cap_high[c*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] per_of(input int c);
        return cap_period[c*CNT_W +: CNT_W];
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pwm(input int p, input int hi, input int per, input int gl);
        pwm_hi[p] = hi;
        pwm_per[p] = per;
        gl_pos[p] = gl;
        ph[p] = 0;
        pwm_on[p] = 1'b1;
    endtask

    task automatic stop_all();
        for (int p = 0; p < 8; p++) begin
            pwm_on[p] = 1'b0;
            pin_static[p] = 1'b0;
        end
    endtask

    task automatic pulse_ack(input logic [3:0] mask);
        cap_ack = mask;
        @(negedge clk);
        cap_ack = 4'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(3);
        checks++; if (cap_high !== '0) begin failures++; $display("FAIL reset_high: got %0h expected 0", cap_high); end
        checks++; if (cap_period !== '0) begin failures++; $display("FAIL reset_period: got %0h expected 0", cap_period); end
        checks++; if (cap_valid !== 4'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0000", cap_valid); end
        checks++; if (cap_overflow !== 4'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0000", cap_overflow); end
        checks++; if (cap_level !== 4'b0) begin failures++; $display("FAIL reset_level: got %b expected 0000", cap_level); end
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_basic();
        stop_all();
        reg_cap_prescale = 4'd0;
        reg_cap_src_1_0 = 8'h03;
        reg_cap_en = 4'b0001;
        wait_cyc(5);
        start_pwm(3, 40, 100, -1);
        wait_cyc(60);
        checks++; if (cap_valid[0] !== 1'b0) begin failures++; $display("FAIL basic_no_partial: got %b expected 0", cap_valid[0]); end
        wait_cyc(50);
        checks++; if (hi_of(0) !== 16'd40) begin failures++; $display("FAIL basic_high: got %0d expected 40", hi_of(0)); end
        checks++; if (per_of(0) !== 16'd100) begin failures++; $display("FAIL basic_period: got %0d expected 100", per_of(0)); end
        checks++; if (cap_valid[0] !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", cap_valid[0]); end
        checks++; if (cap_level[0] !== 1'b1) begin failures++; $display("FAIL basic_level: got %b expected 1", cap_level[0]); end
    endtask

    task automatic test_prescale();
        reg_cap_prescale = 4'd2;
        reg_cap_src_3_2 = 8'h07;
        reg_cap_en = 4'b0101;
        start_pwm(7, 400, 1000, -1);
        wait_cyc(1010);
        checks++; if (hi_of(2) !== 16'd100) begin failures++; $display("FAIL pre_high: got %0d expected 100", hi_of(2)); end
        checks++; if (per_of(2) !== 16'd250) begin failures++; $display("FAIL pre_period: got %0d expected 250", per_of(2)); end
        checks++; if (cap_valid[2] !== 1'b1) begin failures++; $display("FAIL pre_valid: got %b expected 1", cap_valid[2]); end
        pulse_ack(4'b0100);
        checks++; if (cap_valid[2] !== 1'b0) begin failures++; $display("FAIL pre_ack_clear: got %b expected 0", cap_valid[2]); end
        checks++; if (cap_valid[0] !== 1'b1) begin failures++; $display("FAIL pre_ack_other: got %b expected 1", cap_valid[0]); end
        wait_cyc(1000);
        checks++; if (cap_valid[2] !== 1'b1) begin failures++; $display("FAIL pre_revalid: got %b expected 1", cap_valid[2]); end
        checks++; if (per_of(2) !== 16'd250) begin failures++; $display("FAIL pre_period2: got %0d expected 250", per_of(2)); end
        checks++; if (hi_of(0) !== 16'd10) begin failures++; $display("FAIL pre_ch0_high: got %0d expected 10", hi_of(0)); end
        checks++; if (per_of(0) !== 16'd25) begin failures++; $display("FAIL pre_ch0_period: got %0d expected 25", per_of(0)); end
        reg_cap_en = 4'b0000;
        reg_cap_prescale = 4'd0;
        wait_cyc(3);
        checks++; if (cap_valid !== 4'b0) begin failures++; $display("FAIL dis_valid: got %b expected 0000", cap_valid); end
        checks++; if (hi_of(2) !== 16'd100) begin failures++; $display("FAIL dis_hold_high: got %0d expected 100", hi_of(2)); end
        checks++; if (per_of(0) !== 16'd25) begin failures++; $display("FAIL dis_hold_period: got %0d expected 25", per_of(0)); end
    endtask

    task automatic test_overflow();
        stop_all();
        reg_cap_src_1_0 = 8'h10;
        reg_cap_en = 4'b0010;
        wait_cyc(5);
        pin_static[1] = 1'b1;
        wait_cyc(65000);
        checks++; if (cap_overflow[1] !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", cap_overflow[1]); end
        wait_cyc(5000);
        checks++; if (cap_overflow[1] !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", cap_overflow[1]); end
        checks++; if (cap_valid[1] !== 1'b0) begin failures++; $display("FAIL ovf_valid: got %b expected 0", cap_valid[1]); end
        checks++; if (cap_level[1] !== 1'b1) begin failures++; $display("FAIL ovf_level: got %b expected 1", cap_level[1]); end
        start_pwm(1, 10, 20, -1);
        wait_cyc(70);
        checks++; if (hi_of(1) !== 16'd10) begin failures++; $display("FAIL ovf_resume_high: got %0d expected 10", hi_of(1)); end
        checks++; if (per_of(1) !== 16'd20) begin failures++; $display("FAIL ovf_resume_period: got %0d expected 20", per_of(1)); end
        checks++; if (cap_valid[1] !== 1'b1) begin failures++; $display("FAIL ovf_resume_valid: got %b expected 1", cap_valid[1]); end
        checks++; if (cap_overflow[1] !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", cap_overflow[1]); end
        pulse_ack(4'b0010);
        checks++; if (cap_overflow[1] !== 1'b0) begin failures++; $display("FAIL ovf_ack: got %b expected 0", cap_overflow[1]); end
        checks++; if (cap_valid[1] !== 1'b0) begin failures++; $display("FAIL ovf_ack_valid: got %b expected 0", cap_valid[1]); end
        wait_cyc(25);
        checks++; if (cap_valid[1] !== 1'b1) begin failures++; $display("FAIL ovf_revalid: got %b expected 1", cap_valid[1]); end
    endtask

    task automatic test_src_change();
        stop_all();
        reg_cap_en = 4'b0000;
        wait_cyc(3);
        reg_cap_src_1_0 = 8'h03;
        reg_cap_en = 4'b0001;
        wait_cyc(3);
        start_pwm(3, 40, 100, -1);
        start_pwm(5, 20, 100, -1);
        wait_cyc(210);
        checks++; if (hi_of(0) !== 16'd40) begin failures++; $display("FAIL src_first_high: got %0d expected 40", hi_of(0)); end
        pulse_ack(4'b0001);
        wait_cyc(59);
        reg_cap_src_1_0 = 8'h05;
        wait_cyc(40);
        checks++; if (cap_valid[0] !== 1'b0) begin failures++; $display("FAIL src_no_partial: got %b expected 0", cap_valid[0]); end
        checks++; if (per_of(0) !== 16'd100) begin failures++; $display("FAIL src_hold: got %0d expected 100", per_of(0)); end
        wait_cyc(100);
        checks++; if (hi_of(0) !== 16'd20) begin failures++; $display("FAIL src_new_high: got %0d expected 20", hi_of(0)); end
        checks++; if (cap_valid[0] !== 1'b1) begin failures++; $display("FAIL src_new_valid: got %b expected 1", cap_valid[0]); end
        wait_cyc(100);
        rst_n = 1'b0;
        wait_cyc(2);
        checks++; if (cap_high !== '0) begin failures++; $display("FAIL rst_mid_high: got %0h expected 0", cap_high); end
        checks++; if (cap_period !== '0) begin failures++; $display("FAIL rst_mid_period: got %0h expected 0", cap_period); end
        checks++; if (cap_valid !== 4'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0000", cap_valid); end
        checks++; if (cap_overflow !== 4'b0) begin failures++; $display("FAIL rst_mid_overflow: got %b expected 0000", cap_overflow); end
        checks++; if (cap_level !== 4'b0) begin failures++; $display("FAIL rst_mid_level: got %b expected 0000", cap_level); end
        wait_cyc(28);
        rst_n = 1'b1;
        wait_cyc(110);
        checks++; if (cap_valid[0] !== 1'b0) begin failures++; $display("FAIL rst_rearm_valid: got %b expected 0", cap_valid[0]); end
        checks++; if (hi_of(0) !== 16'd0) begin failures++; $display("FAIL rst_rearm_high: got %0d expected 0", hi_of(0)); end
        wait_cyc(60);
        checks++; if (hi_of(0) !== 16'd20) begin failures++; $display("FAIL rst_after_high: got %0d expected 20", hi_of(0)); end
        checks++; if (per_of(0) !== 16'd100) begin failures++; $display("FAIL rst_after_period: got %0d expected 100", per_of(0)); end
        checks++; if (cap_valid[0] !== 1'b1) begin failures++; $display("FAIL rst_after_valid: got %b expected 1", cap_valid[0]); end
    endtask

    task automatic test_glitch();
        logic [CNT_W-1:0] eh;
        logic [CNT_W-1:0] ep;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        eh = 16'd50;
        ep = 16'd100;
`else
        eh = 16'd1;
        ep = 16'd25;
`endif
        stop_all();
        reg_cap_en = 4'b0000;
        wait_cyc(3);
        reg_cap_src_3_2 = 8'h40;
        reg_cap_en = 4'b1000;
        wait_cyc(3);
        start_pwm(4, 50, 100, 75);
        wait_cyc(310);
        checks++; if (hi_of(3) !== eh) begin failures++; $display("FAIL glitch_high: got %0d expected %0d", hi_of(3), eh); end
        checks++; if (per_of(3) !== ep) begin failures++; $display("FAIL glitch_period: got %0d expected %0d", per_of(3), ep); end
        checks++; if (cap_valid[3] !== 1'b1) begin failures++; $display("FAIL glitch_valid: got %b expected 1", cap_valid[3]); end
    endtask

    task automatic test_random();
        int n;
        int h0;
        int p0;
        int maxp;
        logic [2:0] pin_sel[4];
        logic [CNT_W-1:0] eh;
        logic [CNT_W-1:0] ep;
        for (int r = 0; r < 4; r++) begin
            stop_all();
            reg_cap_en = 4'b0000;
            wait_cyc(5);
            n = $urandom_range(0, 2);
            reg_cap_prescale = 4'(n);
            for (int c = 0; c < 4; c++) pin_sel[c] = 3'(2 * c + $urandom_range(0, 1));
            reg_cap_src_1_0 = {1'b0, pin_sel[1], 1'b0, pin_sel[0]};
            reg_cap_src_3_2 = {1'b0, pin_sel[3], 1'b0, pin_sel[2]};
            reg_cap_en = 4'hF;
            wait_cyc(3);
            maxp = 0;
            for (int c = 0; c < 4; c++) begin
                h0 = $urandom_range(3, 30);
                p0 = h0 + $urandom_range(3, 30);
                start_pwm(int'(pin_sel[c]), h0 << n, p0 << n, -1);
                exp_q.push_back(CNT_W'(h0));
                exp_q.push_back(CNT_W'(p0));
                if ((p0 << n) > maxp) maxp = p0 << n;
            end
            wait_cyc(maxp + 12);
            for (int c = 0; c < 4; c++) begin
                eh = exp_q.pop_front();
                ep = exp_q.pop_front();
                checks++; if (hi_of(c) !== eh) begin failures++; $display("FAIL rand_high r%0d c%0d: got %0d expected %0d", r, c, hi_of(c), eh); end
                checks++; if (per_of(c) !== ep) begin failures++; $display("FAIL rand_period r%0d c%0d: got %0d expected %0d", r, c, per_of(c), ep); end
                checks++; if (cap_valid[c] !== 1'b1) begin failures++; $display("FAIL rand_valid r%0d c%0d: got %b expected 1", r, c, cap_valid[c]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        reg_cap_en = 4'b0;
        reg_cap_src_1_0 = 8'h0;
        reg_cap_src_3_2 = 8'h0;
        reg_cap_prescale = 4'd0;
        cap_ack = 4'b0;
        for (int p = 0; p < 8; p++) begin
            pwm_on[p] = 1'b0;
            pin_static[p] = 1'b0;
            gl_pos[p] = -1;
            ph[p] = 0;
            pwm_hi[p] = 0;
            pwm_per[p] = 1;
        end
        test_reset();
        test_basic();
        test_prescale();
        test_overflow();
        test_src_change();
        test_glitch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
